vram_arbiter: RTL
=================

# vram_arbiter

Shares the single-port, synchronous-read video/work RAM between the VGA scanout fetcher and the CPU-side bus. VGA fetches have absolute priority so that pixel timing is never disturbed. CPU reads and writes are served in free cycles through a req/ack handshake. The block sits between the VGA scanout logic, the CPU memory interface and the RAM macro.

## Interface
Parameters:
- `VGA_REGION`, 16'h2000: RAM base address of the frame buffer.
- `VGA_SIZE`, 16'd1200: frame-buffer length in words (40x30 cells); valid VGA offsets are 0..VGA_SIZE-1.

Ports:
- `clock`  in  1: single clock for all logic.
- `reset`  in  1: synchronous, active-high.
- `vga_req`  in  1: VGA fetch request this cycle; not held, one fetch per asserted cycle.
- `vga_addr`  in  16: word offset into the frame buffer.
- `vga_q`  out  16: registered fetch data.
- `vga_valid`  out  1: one-cycle pulse, `vga_q` updated this cycle.
- `cpu_req`  in  1: CPU access request, level, held until `cpu_ack`.
- `cpu_we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  16: absolute RAM address, full range.
- `cpu_wdata`  in  16: write data.
- `cpu_ack`  out  1: one-cycle completion pulse.
- `cpu_rdata`  out  16: read data, valid with `cpu_ack` on reads.
- `cpu_stall`  out  16: saturating count of consecutive cycles the pending CPU request was blocked.
- `mem_addr`  out  16: RAM address, combinational.
- `mem_we`  out  1: RAM write enable, combinational.
- `mem_wdata`  out  16: RAM write data, combinational.
- `mem_q`  in  16: RAM read data, valid the cycle after the address.

## Operation
- **Arbitration cycle N, combinational:**
  - If `vga_req` and `vga_addr < VGA_SIZE`: VGA slot. `mem_addr = VGA_REGION + vga_addr` (16-bit wrap), `mem_we = 0`.
  - Else if state is IDLE and `cpu_req`: CPU slot. `mem_addr = cpu_addr`, `mem_we = cpu_we`, `mem_wdata = cpu_wdata`.
  - Else no access: `mem_addr = 0`, `mem_we = 0`, `mem_wdata = 0`.
- **Out-of-range VGA offset** (`vga_req` with `vga_addr >= VGA_SIZE`):
  - No RAM access is made; the slot is free for the CPU in the same cycle.
  - Still produces a `vga_valid` pulse, with `vga_q = 0`, at normal latency.
- **VGA pipeline:**
  - A 2-stage valid shift (`pend1`, `pend2`) plus a zero flag, tracking fetches in flight.
  - Back-to-back fetches are supported, one per cycle.
- **CPU FSM** (states IDLE, WAIT, ACK):
  - IDLE -> WAIT on a CPU slot grant. `cpu_we`, `cpu_addr` and `cpu_wdata` are sampled only in the grant cycle.
  - WAIT -> ACK unconditionally. For a read, `cpu_rdata <= mem_q`; for a write, `cpu_rdata` holds its value.
  - ACK -> IDLE unconditionally. `cpu_ack = 1` only in ACK.
  - `cpu_req` is ignored in WAIT and ACK, so a request still high during ACK is not re-issued.
- **`cpu_stall` counter:**
  - Increments, saturating at 16'hFFFF, in each cycle with state IDLE, `cpu_req = 1` and the slot taken by VGA.
  - Clears to 0 on a CPU grant, and in any IDLE cycle with `cpu_req = 0`.
- **Write coherence:** a CPU write to the frame buffer is visible to VGA fetches issued in cycle N+1 or later.

## Timing
- **VGA latency 2:** request in cycle N, `mem_q` sampled at the end of N+1, `vga_q` and `vga_valid` visible in N+2. The scanout requester issues fetches 2 pixel clocks ahead.
- **CPU latency:** granted in N, `cpu_ack` and `cpu_rdata` visible in N+2. The earliest next grant is N+3, giving a throughput of one access per 3 cycles with no VGA contention.
- **Values while `reset` is high** (all registered outputs also take these values at the first edge):
  - State IDLE; pipeline flags cleared.
  - `vga_q = 0`, `vga_valid = 0`, `cpu_ack = 0`, `cpu_rdata = 0`, `cpu_stall = 0`.
  - `mem_we` and `mem_addr` forced to 0.
- **Reset mid-transaction:** an in-flight CPU access produces no ack; an in-flight VGA fetch produces no `vga_valid`. The CPU must re-request.
- **VGA slot and CPU request in the same cycle:** VGA wins and the CPU stays in IDLE. There is no fairness guarantee; CPU progress relies on blanking intervals and out-of-range slots.

## Test plan
- **Single read:** memory[16'h2005] = 16'hABCD; `vga_req` = 1 with `vga_addr` = 5 for one cycle -> `mem_addr` = 16'h2005 in the same cycle; `vga_q` = 16'hABCD with `vga_valid` = 1 exactly 2 cycles later, for 1 cycle.
- **CPU write then read, idle VGA:** write 16'h1234 to 16'h0040 -> `mem_we` = 1 in the grant cycle and `cpu_ack` 2 cycles later. Then read 16'h0040 -> `cpu_rdata` = 16'h1234 with `cpu_ack`.
- **Contention:** `vga_req` = 1 for 10 consecutive cycles with in-range offsets and `cpu_req` held from the first cycle -> no CPU grant; `cpu_stall` = 10. CPU grant in cycle 11, ack in cycle 13, `cpu_stall` back to 0.
- **Out-of-range offset:** `vga_addr` = 1200 with `cpu_req` pending -> CPU granted in the same cycle; `vga_valid` pulses with `vga_q` = 0 at N+2.
- **Reset mid-read:** CPU granted at N, `reset` high at N+1 -> no `cpu_ack` ever; all outputs 0. After release, a new request completes normally.
- **Streaming plus saturation:** 1200 back-to-back VGA fetches -> 1200 `vga_valid` pulses with data in address order. Force `cpu_stall` to 16'hFFFE and block 3 more cycles -> it holds at 16'hFFFF.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port video/work RAM arbiter: VGA fetches take the slot outright,
// CPU accesses go through a three-state req/ack FSM in the remaining free cycles.
module vram_arbiter #(
  parameter logic [15:0] VGA_REGION = 16'h2000,
  parameter logic [15:0] VGA_SIZE   = 16'd1200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vga_req,
  input  logic [15:0] vga_addr,
  output logic [15:0] vga_q,
  output logic        vga_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic [15:0] cpu_stall,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_q
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t state, state_nxt;
  logic   vga_hit;
  logic   cpu_grant;
  logic   vld_p1;
  logic   zero_p1;
  logic   we_p1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: slot arbitration and RAM command
  always_comb begin
    vga_hit   = vga_req && (vga_addr < VGA_SIZE);
    cpu_grant = !reset && !vga_hit && (state == IDLE) && cpu_req;
    mem_addr  = 16'h0000;
    mem_we    = 1'b0;
    mem_wdata = 16'h0000;
    if (!reset) begin
      if (vga_hit) begin
        mem_addr = VGA_REGION + vga_addr;
      end else if (cpu_grant) begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cpu_ack   = 1'b0;
    case (state)
      IDLE: if (cpu_grant) state_nxt = WAIT;
      WAIT: state_nxt = ACK;
      ACK: begin
        cpu_ack   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: RAM access in flight; stage p2: returned data registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      zero_p1   <= 1'b0;
      we_p1     <= 1'b0;
      vga_valid <= 1'b0;
      vga_q     <= 16'h0000;
      cpu_rdata <= 16'h0000;
      cpu_stall <= 16'h0000;
    end else begin
      state     <= state_nxt;
      vld_p1    <= vga_req;
      zero_p1   <= !vga_hit;
      vga_valid <= vld_p1;
      if (vld_p1) vga_q <= zero_p1 ? 16'h0000 : mem_q;
      if (cpu_grant) we_p1 <= cpu_we;
      if (state == WAIT && !we_p1) cpu_rdata <= mem_q;
      // Stall only tracks a request that is actually waiting in IDLE
      if (state == IDLE) begin
        if (cpu_grant || !cpu_req) cpu_stall <= 16'h0000;
        else if (vga_hit)          cpu_stall <= sat_inc(cpu_stall);
      end
    end
  end

endmodule
